// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared fetch FSM state encoding and fetch-stage defaults.
package if_fetch_stage_pkg;
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_KILL = 2'd2
    } fetch_state_t;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: req/ack instruction-memory bus between fetch stage and memory.
interface if_fetch_stage_if #(parameter int XLEN = 32);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [31:0]     rdata;
    modport master(output req, addr, input ack, rdata);
    modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load enable; flush beats enable and inserts a bubble.
module if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc4,
    input  logic [31:0]     i_inst,
    input  logic            i_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc4,
    output logic [31:0]     o_inst,
    output logic            o_valid
);
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;
    logic [31:0]     r_inst;
    logic            r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_pc4   <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_pc    <= i_pc;
            r_pc4   <= i_pc4;
            r_inst  <= i_valid ? i_inst : NOP_INST;
            r_valid <= i_valid;
        end
    end

    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, fetch FSM (REQ/HOLD/KILL) and one-entry hold buffer feeding the IF/ID register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter logic [31:0]     NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pipeline_stop,
    input  logic              i_if_id_flush,
    input  logic [XLEN-1:0]   i_br_target,
    if_fetch_stage_if.master  imem,
    output logic [XLEN-1:0]   o_id_pc,
    output logic [XLEN-1:0]   o_id_pc4,
    output logic [31:0]       o_id_inst,
    output logic              o_id_valid,
    output logic [1:0]        o_fetch_state
);
    fetch_state_t    r_state, w_next_state;
    logic [XLEN-1:0] r_pc, w_next_pc;
    logic [XLEN-1:0] r_redir, w_next_redir;
    logic [XLEN-1:0] r_buf_pc;
    logic [31:0]     r_buf_inst;
    logic            w_buf_we;
    logic            w_load;
    logic            w_bubble;
    logic [XLEN-1:0] w_load_pc;
    logic [31:0]     w_load_inst;

    // KILL keeps the old request on the bus; the redirect target waits in r_redir
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_redir = r_redir;
        w_buf_we     = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (i_if_id_flush) begin
                    if (imem.ack) w_next_pc = i_br_target;
                    else begin
                        w_next_state = ST_KILL;
                        w_next_redir = i_br_target;
                    end
                end else if (imem.ack && i_pipeline_stop) begin
                    w_next_state = ST_HOLD;
                    w_buf_we     = 1'b1;
                end else if (imem.ack) w_next_pc = r_pc + XLEN'(4);
            end
            ST_HOLD: begin
                if (i_if_id_flush) begin
                    w_next_state = ST_REQ;
                    w_next_pc    = i_br_target;
                end else if (!i_pipeline_stop) begin
                    w_next_state = ST_REQ;
                    w_next_pc    = r_pc + XLEN'(4);
                end
            end
            ST_KILL: begin
                if (imem.ack) begin
                    w_next_state = ST_REQ;
                    w_next_pc    = i_if_id_flush ? i_br_target : r_redir;
                end else if (i_if_id_flush) w_next_redir = i_br_target;
            end
            default: w_next_state = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_REQ;
            r_pc       <= RESET_PC;
            r_redir    <= RESET_PC;
            r_buf_pc   <= '0;
            r_buf_inst <= NOP_INST;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_redir <= w_next_redir;
            if (w_buf_we) begin
                r_buf_pc   <= r_pc;
                r_buf_inst <= imem.rdata;
            end
        end
    end

    assign w_load      = !i_if_id_flush && !i_pipeline_stop &&
                         ((r_state == ST_REQ && imem.ack) || r_state == ST_HOLD);
    assign w_bubble    = i_if_id_flush || (!i_pipeline_stop && !w_load);
    assign w_load_pc   = (r_state == ST_HOLD) ? r_buf_pc : r_pc;
    assign w_load_inst = (r_state == ST_HOLD) ? r_buf_inst : imem.rdata;

    if_id_reg #(.XLEN(XLEN), .NOP_INST(NOP_INST)) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_load),
        .i_flush (w_bubble),
        .i_pc    (w_load_pc),
        .i_pc4   (w_load_pc + XLEN'(4)),
        .i_inst  (w_load_inst),
        .i_valid (1'b1),
        .o_pc    (o_id_pc),
        .o_pc4   (o_id_pc4),
        .o_inst  (o_id_inst),
        .o_valid (o_id_valid)
    );

    assign imem.req      = (r_state != ST_HOLD);
    assign imem.addr     = r_pc;
    assign o_fetch_state = r_state;
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID-stage hazard/forwarding logic. It owns the PC and drives a req/ack instruction-memory handshake with variable latency. It consumes the hazard unit's pipeline_stop and if_id_flush plus the branch target, and presents {pc, pc+4, inst, valid} to ID. Memory latency and redirects are absorbed by a small FSM with a one-entry hold buffer.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) presented when invalid

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pipeline_stop  in  1  hazard unit stall; IF/ID and PC must hold
if_id_flush  in  1  branch redirect; IF/ID becomes bubble, PC <= br_target
br_target  in  XLEN  redirect address, valid when if_id_flush=1
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address, stable while imem_req=1 and no ack
imem_ack  in  1  one-cycle pulse, imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
id_pc  out  XLEN  PC of instruction in ID
id_pc4  out  XLEN  id_pc+4
id_inst  out  32  instruction in ID (NOP_INST when id_valid=0)
id_valid  out  1  ID slot holds a real instruction
fetch_state  out  2  FSM state, for debug/coverage

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=REQ, id_valid=0, id_pc=0, id_pc4=0, id_inst=NOP_INST, hold buffer invalid. imem_req=1 from first cycle after release.
- imem_addr = pc at all times; imem_req=1 in REQ and KILL, 0 in HOLD.
- Handshake rule: once imem_req=1 it stays high with unchanged imem_addr until imem_ack; a request is never withdrawn.
- States: REQ (request outstanding, data wanted), KILL (request outstanding, data to be discarded), HOLD (data received, buffered because ID stalled).
- REQ, no ack, no flush: if pipeline_stop=0, IF/ID loads bubble (id_valid<=0); if stop=1, IF/ID holds. Stay REQ.
- REQ, ack, no flush, stop=0: IF/ID <= {pc, pc+4, rdata, 1}; pc<=pc+4; stay REQ (back-to-back fetch, 1 instr/cycle at zero-wait memory).
- REQ, ack, no flush, stop=1: buffer <= {pc, rdata}; IF/ID holds; pc unchanged; ->HOLD.
- HOLD, stop=1: hold all. HOLD, stop=0: IF/ID <= buffer with valid=1; pc<=pc+4; ->REQ.
- Flush (any state) takes priority over stop and over ack: IF/ID <= bubble, pc<=br_target, buffer dropped. From REQ with ack same cycle -> REQ (data discarded). From REQ without ack -> KILL. From HOLD -> REQ. From KILL -> KILL.
- KILL: on ack, discard data, ->REQ (now requesting pc=br_target). Without ack stay KILL; IF/ID bubble unless stop=1.
- KILL ignores the ack's data in all cases; imem_addr in KILL is still the old address (handshake rule) — pc holds target in a separate redirect register, which drives imem_addr when returning to REQ.
- Stop with flush simultaneously: flush wins (bubble), per hazard unit's load+branch priority.
- Arithmetic: pc+4 modulo 2^XLEN; wrap from 32'hFFFF_FFFC to 0 without error. br_target low 2 bits passed unmodified (misalignment is not checked here).
- fetch_state encoding: REQ=0, HOLD=1, KILL=2.

Decomposition:
- Shared package: state enum (REQ/HOLD/KILL), NOP_INST constant, RESET_PC default.
- One sub-module: if_id_reg (enable/flush pipeline register for {pc, pc4, inst, valid}, flush priority, reset to bubble); FSM, PC and hold buffer in the top.

Test Plan:
- Reset release, zero-wait ack every cycle -> id_pc 0,4,8,... on consecutive cycles, id_valid=1 from the second cycle.
- Ack with 3-cycle latency -> imem_addr stable for 3 cycles; two bubbles (id_valid=0, id_inst=32'h13) between valid instructions.
- Ack while pipeline_stop=1 for 2 cycles at pc=0x10 -> HOLD, imem_req=0; after stop drops, id_pc=0x10 with the buffered instruction, next request at 0x14.
- Flush with br_target=0x100 while a request to 0x20 is outstanding (ack 2 cycles later) -> KILL, 0x20 data never reaches ID; next request at 0x100.
- Flush and stop asserted together with ack in the same cycle -> IF/ID bubble, pc=br_target, state REQ.
- pc=32'hFFFF_FFFC ack -> id_pc4=0, next imem_addr=0; rst_n asserted mid-KILL -> all outputs at reset values immediately.
